// File: rtl/alu_sin_flags.sv
// alu_sin_flags: N-bit registered ALU with add, subtract, XOR and NOT of A.
// The only status output is the registered adder carry-out.
// ADD and SUB share one adder. The B operand passes through an invert mux,
// and carry-in comes from ALUControl[0].
module alu_sin_flags #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   ALUControl,
    output logic [N-1:0] out,
    output logic         cout,
    input  logic         clk,
    input  logic         rst
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    logic [N-1:0] b_mux;
    logic [N:0]   sum;
    logic [N-1:0] result;
    logic         carry;

    // Shared adder. SUB selects ~B and a carry-in of 1, so A - B = A + ~B + 1.
    always_comb begin
        b_mux = ALUControl[0] ? ~B : B;
        sum   = {1'b0, A} + {1'b0, b_mux} + {{N{1'b0}}, ALUControl[0]};
    end

    // Select the result combinationally. Carry is only meaningful on the arithmetic ops.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (ALUControl)
            OP_ADD,
            OP_SUB: begin
                result = sum[N-1:0];
                carry  = sum[N];
            end
            OP_XOR: result = A ^ B;
            OP_NOT: result = ~A;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    // Output register. Reset has priority and discards the operation sampled on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            cout <= 1'b0;
        end else begin
            out  <= result;
            cout <= carry;
        end
    end

endmodule

// File: tb/tb_alu_sin_flags.sv
// Scoreboard bench for alu_sin_flags at N = 4.
// The driver pushes a hand-computed expected result for each vector.
// The monitor pops one entry after every rising edge and compares it with the DUT output.
module tb_alu_sin_flags;

    localparam int N = 4;

    logic [N-1:0] A, B;
    logic [1:0]   ALUControl;
    logic [N-1:0] out;
    logic         cout;
    logic         clk;
    logic         rst;

    typedef struct packed {
        logic [N-1:0] o;
        logic         c;
        logic [7:0]   id;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int vec_id   = 0;

    alu_sin_flags #(.N(N)) dut (
        .A(A),
        .B(B),
        .ALUControl(ALUControl),
        .out(out),
        .cout(cout),
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a vector for the next rising edge, record the expected result, then move to the falling edge.
    task automatic drive(input logic r, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] op, input logic [N-1:0] eo, input logic ec);
        exp_t e;
        rst        = r;
        A          = a;
        B          = b;
        ALUControl = op;
        e.o  = eo;
        e.c  = ec;
        e.id = 8'(vec_id);
        exp_q.push_back(e);
        vec_id++;
        @(negedge clk);
    endtask

    // Monitor: the registered result for each vector is valid one edge after it was applied.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out !== e.o || cout !== e.c) begin
                    failures++;
                    $display("FAIL vec%0d: out=%0d cout=%0b, required out=%0d cout=%0b",
                             e.id, out, cout, e.o, e.c);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for two edges, with a live vector on the inputs.
        drive(1, 4'd3,  4'd14, 2'b00, 4'd0,  1'b0);
        drive(1, 4'd3,  4'd14, 2'b00, 4'd0,  1'b0);
        // The reset is released, so the same vector now produces a result.
        drive(0, 4'd3,  4'd14, 2'b00, 4'd1,  1'b1);
        // ADD
        drive(0, 4'd2,  4'd6,  2'b00, 4'd8,  1'b0);
        drive(0, 4'd7,  4'd4,  2'b00, 4'd11, 1'b0);
        drive(0, 4'd15, 4'd1,  2'b00, 4'd0,  1'b1);
        // SUB
        drive(0, 4'd3,  4'd14, 2'b01, 4'd5,  1'b0);
        drive(0, 4'd2,  4'd6,  2'b01, 4'd12, 1'b0);
        drive(0, 4'd7,  4'd4,  2'b01, 4'd3,  1'b1);
        drive(0, 4'd5,  4'd5,  2'b01, 4'd0,  1'b1);
        drive(0, 4'd0,  4'd1,  2'b01, 4'd15, 1'b0);
        // XOR
        drive(0, 4'd3,  4'd14, 2'b10, 4'd13, 1'b0);
        drive(0, 4'd2,  4'd6,  2'b10, 4'd4,  1'b0);
        drive(0, 4'd7,  4'd4,  2'b10, 4'd3,  1'b0);
        // NOT: B is ignored.
        drive(0, 4'd3,  4'd14, 2'b11, 4'd12, 1'b0);
        drive(0, 4'd2,  4'd6,  2'b11, 4'd13, 1'b0);
        drive(0, 4'd7,  4'd4,  2'b11, 4'd8,  1'b0);
        drive(0, 4'd7,  4'd0,  2'b11, 4'd8,  1'b0);
        drive(0, 4'd7,  4'd15, 2'b11, 4'd8,  1'b0);
        // Alternating ops back to back, with a one-cycle reset in the middle.
        drive(0, 4'd9,  4'd9,  2'b00, 4'd2,  1'b1);
        drive(0, 4'd9,  4'd10, 2'b01, 4'd15, 1'b0);
        drive(0, 4'd12, 4'd10, 2'b10, 4'd6,  1'b0);
        drive(0, 4'd0,  4'd5,  2'b11, 4'd15, 1'b0);
        drive(0, 4'd8,  4'd7,  2'b00, 4'd15, 1'b0);
        drive(1, 4'd6,  4'd2,  2'b01, 4'd0,  1'b0);
        drive(0, 4'd6,  4'd2,  2'b01, 4'd4,  1'b1);
        drive(0, 4'd15, 4'd15, 2'b10, 4'd0,  1'b0);
        drive(0, 4'd15, 4'd3,  2'b11, 4'd0,  1'b0);
        drive(0, 4'd15, 4'd15, 2'b00, 4'd14, 1'b1);
        drive(0, 4'd1,  4'd2,  2'b01, 4'd15, 1'b0);

        // Let the monitor consume the final entry, then confirm every expectation was checked.
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
